// File: rtl/mul_accumulator.sv
// Sums COUNT unsigned 8-bit products into an ACC_W-bit result with a sticky overflow flag.
// Define MUL_ACCUMULATOR_SAT_EN to saturate at 2^ACC_W-1 instead of wrapping.
module mul_accumulator #(
  parameter int COUNT = 16,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o_dbg_state
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the producer holds its data until the transfer edge.
  assign w_accept = in_valid && w_in_ready;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, prod};
  assign w_carry  = w_sum[ACC_W];

`ifdef MUL_ACCUMULATOR_SAT_EN
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = !clr;
        if (w_accept && w_last) w_next_state = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next_state = ACCUM;
      end
      default: w_next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ACCUM: begin
          if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_carry;
          end
        end
        HOLD: begin
          // clr is deliberately ignored here so a finished result is never dropped.
          if (out_ready) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign acc_out     = r_acc;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mul_accumulator.md
MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Interface
REQ-001 SHALL have parameter COUNT, default 16, giving the number of products summed per result (2..256).
REQ-002 SHALL have parameter ACC_W, default 10, giving the accumulator and result width in bits (8..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port prod, input, 8, the unsigned product from the upstream 4x4 multiplier stage.
REQ-006 SHALL have port in_valid, input, 1, meaning prod is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts prod this cycle.
REQ-008 SHALL have port clr, input, 1, a synchronous discard of the partial sum.
REQ-009 SHALL have port acc_out, output, ACC_W, the completed sum.
REQ-010 SHALL have port ovf, output, 1, a sticky overflow flag for the current result.
REQ-011 SHALL have port out_valid, output, 1, meaning acc_out and ovf are valid.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream takes the result.

Function
REQ-013 SHALL implement a two-state FSM, ACCUM and HOLD, with reset state ACCUM.
REQ-014 SHALL drive in_ready = (state==ACCUM) && !clr, as a combinational function of registered state and clr.
REQ-015 SHALL define accept as in_valid && in_ready; on accept, acc <= acc + zero-extended prod and cnt <= cnt + 1.
REQ-016 SHALL sum modulo 2^ACC_W; on any carry out of bit ACC_W-1, ovf <= 1, sticky until the result is taken.
REQ-017 SHALL, on an accept with cnt == COUNT-1, go to HOLD on the same edge with acc holding the final sum; out_valid = 1 on the following cycle.
REQ-018 SHALL make the result latency exactly 1 cycle from the final accepting edge to out_valid high.
REQ-019 SHALL drive out_valid = (state==HOLD); acc_out and ovf SHALL stay stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, clear acc, cnt and ovf to 0 and return to ACCUM; in_ready rises the next cycle (no same-cycle bypass).
REQ-021 SHALL, on clr in ACCUM, zero acc, cnt and ovf, accept no product that cycle, and stay in ACCUM.
REQ-022 SHALL ignore clr in HOLD: the pending result is never discarded.
REQ-023 SHALL hold cnt at ceil(log2 COUNT) bits; cnt never exceeds COUNT-1.
REQ-024 SHALL, when in_valid is low, hold acc, cnt and ovf; bubbles between products are allowed.
REQ-025 SHALL drive acc_out = acc in both states; acc_out is meaningful only while out_valid is high.

Reset
REQ-026 SHALL, on rst high at a clock edge, set state=ACCUM, acc=0, cnt=0, ovf=0, so out_valid=0, acc_out=0, and in_ready=!clr from the next cycle.
REQ-027 SHALL let rst override every other input, including mid-accumulation and during HOLD; a pending result is lost.
REQ-028 SHALL ignore inputs and perform no accept during a reset cycle.

Configuration
REQ-029 SHALL support macro MUL_ACCUMULATOR_SAT_EN; when defined, an overflowing add loads acc = 2^ACC_W-1 and later adds keep it saturated. ovf behaviour is unchanged.
REQ-030 SHALL, when MUL_ACCUMULATOR_SAT_EN is undefined, wrap modulo 2^ACC_W as in REQ-016.

Verification
REQ-031 SHALL check: COUNT=4, prods 10,20,30,40 back-to-back, out_ready=1 -> acc_out=100, ovf=0, out_valid high exactly 1 cycle after the 4th accept, in_ready high the cycle after.
REQ-032 SHALL check: defaults, 16 x prod=225 -> wrap build acc_out=528, ovf=1; SAT build acc_out=1023, ovf=1.
REQ-033 SHALL check: COUNT=4, 4 prods of 5, out_ready=0 for 6 cycles -> acc_out=20 stable, in_ready=0, extra in_valid pulses not accepted, then one handshake.
REQ-034 SHALL check: COUNT=4, prods 7,9 then clr together with in_valid prod=50, then 1,2,3,4 -> that 50 not accepted, acc_out=10.
REQ-035 SHALL check: rst after 2 of 4 accepts, and rst during HOLD -> out_valid=0, acc_out=0 next cycle; the next 4 prods of 1 give acc_out=4.
REQ-036 SHALL check: COUNT=4, in_valid toggling 1/0 with prods 1,2,3,4 -> acc_out=10, result latency unchanged.
